// File: rtl/cpu_clock_ctrl.sv
// Debug clock controller: HALT/RUN/STEP/BURST modes driving a CPU clock enable.
// Optional breakpoint compare is built when CLK_BREAKPOINT_EN is defined.
module cpu_clock_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int BURST_W    = 8,
    parameter int CYC_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode_btn,
    input  logic               step_btn,
    input  logic               burst_btn,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt_req,
    input  logic               clr_cnt,
`ifdef CLK_BREAKPOINT_EN
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    output logic               bp_hit,
`endif
    output logic               clk_en,
    output logic [1:0]         state,
    output logic [CYC_W-1:0]   cycle_cnt
);

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BURST = 2'd3;

    localparam int NB = 3;
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 65535 || BURST_W < 1 ||
        CYC_W < 1 || PC_W < 1) begin : g_bad_cfg
        $error("cpu_clock_ctrl: parameter out of range");
    end

    // Button index: 0 = mode, 1 = step, 2 = burst
    logic [NB-1:0] raw_btn;
    logic [NB-1:0] s1_q, s1_d;
    logic [NB-1:0] s2_q, s2_d;
    logic [NB-1:0] lvl_q, lvl_d;
    logic [NB-1:0] p_q, p_d;
    logic [15:0]   dcnt_q [NB];
    logic [15:0]   dcnt_d [NB];

    logic mode_p;
    logic step_p;
    logic burst_p;

    logic [1:0]         state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               clk_en_q, clk_en_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic               bp_stop;

    assign raw_btn = {burst_btn, step_btn, mode_btn};
    assign mode_p  = p_q[0];
    assign step_p  = p_q[1];
    assign burst_p = p_q[2];

    // Synchronise buttons and debounce; pulse once when a level settles high
    always_comb begin
        s1_d = raw_btn;
        s2_d = s1_q;
        lvl_d = lvl_q;
        p_d = '0;
        for (int i = 0; i < NB; i++) begin
            dcnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    lvl_d[i] = s2_q[i];
                    p_d[i]   = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Synchroniser, debounce counters, levels and press pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            lvl_q <= '0;
            p_q   <= '0;
            for (int i = 0; i < NB; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            lvl_q <= lvl_d;
            p_q   <= p_d;
            for (int i = 0; i < NB; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    // Mode FSM; halt_req and mode press outrank everything else
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_HALT: begin
                if (!halt_req) begin
                    if (mode_p) begin
                        state_d = ST_RUN;
                    end else if (step_p) begin
                        state_d = ST_STEP;
                    end else if (burst_p && burst_len != '0) begin
                        state_d = ST_BURST;
                        rem_d   = burst_len;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req || mode_p || bp_stop) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_BURST: begin
                if (halt_req || mode_p || bp_stop) begin
                    state_d = ST_HALT;
                end else if (rem_q == BURST_W'(1)) begin
                    state_d = ST_HALT;
                end else begin
                    rem_d = rem_q - BURST_W'(1);
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Enable is registered from the next state so it never glitches
    always_comb begin
        clk_en_d = (state_d != ST_HALT);
    end

    // Executed-cycle counter; clear beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (clk_en_q) begin
            cnt_d = cnt_q + CYC_W'(1);
        end
    end

    // State, burst remainder, enable and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_HALT;
            rem_q    <= '0;
            clk_en_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            clk_en_q <= clk_en_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef CLK_BREAKPOINT_EN
    logic first_q, first_d;
    logic bp_hit_q, bp_hit_d;
    logic bp_fire;

    // Skip the compare on the first enabled cycle so a resume steps off
    assign bp_fire = bp_en && (pc == bp_addr) && !first_q &&
                     (state_q == ST_RUN || state_q == ST_BURST);
    assign bp_stop = bp_fire;

    // Track first cycle out of HALT; bp_hit sticks until the next resume
    always_comb begin
        first_d  = (state_q == ST_HALT);
        bp_hit_d = bp_hit_q;
        if (state_q == ST_HALT && state_d != ST_HALT) begin
            bp_hit_d = 1'b0;
        end else if (bp_fire && !halt_req && !mode_p) begin
            bp_hit_d = 1'b1;
        end
    end

    // Breakpoint bookkeeping registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_q  <= 1'b1;
            bp_hit_q <= 1'b0;
        end else begin
            first_q  <= first_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif

    assign clk_en    = clk_en_q;
    assign state     = state_q;
    assign cycle_cnt = cnt_q;

endmodule
